// File: rtl/soc_rtc_ctrl.sv
// Bus-side controller for the RTC core: sequences CPU COUNT accesses through the
// rtc_we/rtc_ready handshake, keeps a shadow of the count and raises an alarm irq.
module soc_rtc_ctrl #(
  parameter int IO_MAP_WIDTH   = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    io_sel,
  input  logic                    io_we,
  input  logic [1:0]              io_addr,
  input  logic [IO_MAP_WIDTH-1:0] io_wdata,
  output logic [IO_MAP_WIDTH-1:0] io_rdata,
  output logic                    io_ready,
  output logic [IO_MAP_WIDTH-1:0] rtc_wdata,
  output logic                    rtc_we,
  input  logic [IO_MAP_WIDTH-1:0] rtc_rdata,
  input  logic                    rtc_ready,
  output logic                    irq,
  output logic [1:0]              dbg_state
);

  // CPU handshake: io_sel is held with addr/we/wdata stable until the single
  // io_ready cycle; the RTC accepts a load on any edge with rtc_we & rtc_ready.
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    RTC_WR = 2'd2,
    RTC_RD = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [TW-1:0]           r_tcnt;
  logic [IO_MAP_WIDTH-1:0] r_io_rdata;
  logic [IO_MAP_WIDTH-1:0] r_rtc_wdata;
  logic                    r_rtc_we;
  logic [IO_MAP_WIDTH-1:0] r_alarm;
  logic [IO_MAP_WIDTH-1:0] r_shadow;
  logic                    r_alarm_en;
  logic                    r_pending;
  logic                    r_timeout;
  logic                    r_match_q;

  logic                    w_reg_acc;
  logic                    w_start_wr;
  logic                    w_start_rd;
  logic                    w_wr_done;
  logic                    w_rd_done;
  logic                    w_tmo;
  logic                    w_waiting;
  logic                    w_match;
  logic                    w_pend_set;
  logic                    w_ctrl_wr;
  logic [IO_MAP_WIDTH-1:0] w_reg_rdata;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_reg_acc  = 1'b0;
    w_start_wr = 1'b0;
    w_start_rd = 1'b0;
    w_wr_done  = 1'b0;
    w_rd_done  = 1'b0;
    w_tmo      = 1'b0;
    w_waiting  = 1'b0;
    case (r_state)
      IDLE: begin
        if (io_sel) begin
          if (io_addr != 2'd0) begin
            w_reg_acc = 1'b1;
            w_next    = ACK;
          end else if (io_we) begin
            w_start_wr = 1'b1;
            w_next     = RTC_WR;
          end else begin
            w_start_rd = 1'b1;
            w_next     = RTC_RD;
          end
        end
      end
      RTC_WR, RTC_RD: begin
        if (rtc_ready) begin
          w_wr_done = (r_state == RTC_WR);
          w_rd_done = (r_state == RTC_RD);
          w_next    = ACK;
        end else if (r_tcnt == TMO_MAX) begin
          w_tmo  = 1'b1;
          w_next = ACK;
        end else begin
          w_waiting = 1'b1;
        end
      end
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_reg_rdata = '0;
    case (io_addr)
      2'd1:    w_reg_rdata = r_alarm;
      2'd2:    w_reg_rdata = {{(IO_MAP_WIDTH-3){1'b0}}, r_timeout, r_pending, r_alarm_en};
      default: w_reg_rdata = '0;
    endcase
  end

  assign w_match    = (r_shadow == r_alarm);
  assign w_pend_set = w_match & ~r_match_q & r_alarm_en;
  assign w_ctrl_wr  = w_reg_acc & io_we & (io_addr == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcnt      <= '0;
      r_io_rdata  <= '0;
      r_rtc_wdata <= '0;
      r_rtc_we    <= 1'b0;
      r_alarm     <= '0;
      r_shadow    <= '0;
      r_alarm_en  <= 1'b0;
      r_pending   <= 1'b0;
      r_timeout   <= 1'b0;
      r_match_q   <= 1'b0;
    end else begin
      r_match_q <= w_match;
      if (w_start_wr || w_start_rd) r_tcnt <= '0;
      else if (w_waiting)           r_tcnt <= r_tcnt + 1'b1;

      if (w_start_wr) begin
        r_rtc_wdata <= io_wdata;
        r_rtc_we    <= 1'b1;
      end else if (w_wr_done || w_tmo) begin
        r_rtc_we <= 1'b0;
      end

      if (w_reg_acc && !io_we)                 r_io_rdata <= w_reg_rdata;
      else if (w_rd_done)                      r_io_rdata <= rtc_rdata;
      else if (w_tmo && (r_state == RTC_RD))   r_io_rdata <= '1;

      // Shadow tracks the core while idle and follows every completed access.
      if (w_wr_done)                             r_shadow <= r_rtc_wdata;
      else if (w_rd_done)                        r_shadow <= rtc_rdata;
      else if ((r_state == IDLE) && rtc_ready)   r_shadow <= rtc_rdata;

      if (w_reg_acc && io_we && (io_addr == 2'd1)) r_alarm <= io_wdata;
      if (w_ctrl_wr) r_alarm_en <= io_wdata[0];
      // A hardware set on the same edge as a W1C clear takes precedence.
      r_pending <= w_pend_set | (r_pending & ~(w_ctrl_wr & io_wdata[1]));
      r_timeout <= w_tmo      | (r_timeout & ~(w_ctrl_wr & io_wdata[2]));
    end
  end

  assign io_rdata  = r_io_rdata;
  assign io_ready  = (r_state == ACK);
  assign rtc_wdata = r_rtc_wdata;
  assign rtc_we    = r_rtc_we;
  assign irq       = r_pending & r_alarm_en;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_soc_rtc_ctrl.sv
// Directed bench for soc_rtc_ctrl: register access, COUNT handshake, timeout,
// alarm interrupt and W1C collision behaviour.
module tb_soc_rtc_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         io_sel;
  logic         io_we;
  logic [1:0]   io_addr;
  logic [W-1:0] io_wdata;
  logic [W-1:0] io_rdata;
  logic         io_ready;
  logic [W-1:0] rtc_wdata;
  logic         rtc_we;
  logic [W-1:0] rtc_rdata;
  logic         rtc_ready;
  logic         irq;
  logic [1:0]   dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  soc_rtc_ctrl #(.IO_MAP_WIDTH(W), .TIMEOUT_CYCLES(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .io_sel    (io_sel),
    .io_we     (io_we),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .io_ready  (io_ready),
    .rtc_wdata (rtc_wdata),
    .rtc_we    (rtc_we),
    .rtc_rdata (rtc_rdata),
    .rtc_ready (rtc_ready),
    .irq       (irq),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: one CPU access, inputs changed 1ns after a rising edge. cycles counts
  // edges from the first one that samples io_sel up to the edge entering ACK.
  task automatic cpu_access(input logic we, input logic [1:0] addr, input logic [W-1:0] wdata,
                            output logic [W-1:0] rdata, output int cycles);
    @(posedge clk); #1;
    io_sel = 1'b1; io_we = we; io_addr = addr; io_wdata = wdata;
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!io_ready && cycles < 200);
    rdata  = io_rdata;
    io_sel = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] rd;
    int cyc;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({io_ready, rtc_we, irq, dbg_state} !== 5'b0 || io_rdata !== '0 || rtc_wdata !== '0) begin
      tests_failed++;
      $display("FAIL reset_values: ready=%b we=%b irq=%b st=%0d rdata=%h wdata=%h required all 0",
               io_ready, rtc_we, irq, dbg_state, io_rdata, rtc_wdata);
    end
    rst = 1'b0;
    rtc_ready = 1'b0;
    io_sel = 1'b1; io_we = 1'b1; io_addr = 2'd0; io_wdata = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (rtc_we !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_pre_we: rtc_we=%b required 1", rtc_we);
    end
    rst = 1'b1; io_sel = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (rtc_we !== 1'b0 || io_ready !== 1'b0 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_abort: we=%b ready=%b st=%0d required 0/0/0", rtc_we, io_ready, dbg_state);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (io_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_ack: io_ready=%b required 0", io_ready);
    end
    cpu_access(1'b0, 2'd2, '0, rd, cyc);
    tests_run++;
    if (rd !== 32'h0 || cyc != 1) begin
      tests_failed++;
      $display("FAIL reset_ctrl: rdata=%h cycles=%0d required 0 / 1", rd, cyc);
    end
  endtask

  task automatic test_alarm_rw();
    logic [W-1:0] rd;
    int cyc;
    cpu_access(1'b1, 2'd1, 32'h0000_0010, rd, cyc);
    tests_run++;
    if (cyc != 1) begin
      tests_failed++;
      $display("FAIL alarm_wr_latency: cycles=%0d required 1", cyc);
    end
    cpu_access(1'b0, 2'd1, '0, rd, cyc);
    tests_run++;
    if (rd !== 32'h0000_0010 || cyc != 1) begin
      tests_failed++;
      $display("FAIL alarm_rd: rdata=%h cycles=%0d required 00000010 / 1", rd, cyc);
    end
    cpu_access(1'b1, 2'd3, 32'hFFFF_FFFF, rd, cyc);
    cpu_access(1'b0, 2'd3, '0, rd, cyc);
    tests_run++;
    if (rd !== 32'h0 || cyc != 1) begin
      tests_failed++;
      $display("FAIL reserved_rd: rdata=%h cycles=%0d required 0 / 1", rd, cyc);
    end
  endtask

  task automatic test_count_write();
    logic [W-1:0] rd;
    int cyc;
    int we_cnt = 0;
    int ready_cnt = 0;
    int ready_at = 0;
    int bad_wdata = 0;
    rtc_ready = 1'b0;
    rtc_rdata = 32'h1234_5679;
    @(posedge clk); #1;
    io_sel = 1'b1; io_we = 1'b1; io_addr = 2'd0; io_wdata = 32'h1234_5678;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (rtc_we) begin
        we_cnt++;
        if (rtc_wdata !== 32'h1234_5678) bad_wdata++;
      end
      if (io_ready) begin
        ready_cnt++;
        ready_at = k;
        io_sel = 1'b0;
      end
      if (k == 6) rtc_ready = 1'b1;
    end
    tests_run++;
    if (we_cnt != 6 || bad_wdata != 0) begin
      tests_failed++;
      $display("FAIL cnt_wr_we: we_cycles=%0d bad_wdata=%0d required 6 / 0", we_cnt, bad_wdata);
    end
    tests_run++;
    if (ready_cnt != 1 || ready_at != 7) begin
      tests_failed++;
      $display("FAIL cnt_wr_ack: pulses=%0d at=%0d required 1 at 7", ready_cnt, ready_at);
    end
    cpu_access(1'b0, 2'd0, '0, rd, cyc);
    tests_run++;
    if (rd !== 32'h1234_5679 || cyc != 2) begin
      tests_failed++;
      $display("FAIL cnt_rd: rdata=%h cycles=%0d required 12345679 / 2", rd, cyc);
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] rd;
    int cyc;
    rtc_ready = 1'b0;
    cpu_access(1'b0, 2'd0, '0, rd, cyc);
    // one edge to enter RTC_RD plus 65 waiting cycles
    tests_run++;
    if (rd !== 32'hFFFF_FFFF || cyc != 66) begin
      tests_failed++;
      $display("FAIL timeout_rd: rdata=%h cycles=%0d required ffffffff / 66", rd, cyc);
    end
    cpu_access(1'b0, 2'd2, '0, rd, cyc);
    tests_run++;
    if (rd !== 32'h4) begin
      tests_failed++;
      $display("FAIL timeout_flag: ctrl=%h required 00000004", rd);
    end
    cpu_access(1'b1, 2'd2, 32'h4, rd, cyc);
    cpu_access(1'b0, 2'd2, '0, rd, cyc);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL timeout_w1c: ctrl=%h required 00000000", rd);
    end
  endtask

  task automatic test_alarm_irq();
    logic [W-1:0] rd;
    int cyc;
    int irq_seen = 0;
    rtc_ready = 1'b1;
    rtc_rdata = 32'h1E;
    cpu_access(1'b1, 2'd1, 32'h20, rd, cyc);
    cpu_access(1'b1, 2'd2, 32'h1, rd, cyc);
    @(posedge clk); #1;
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_idle: irq=%b required 0", irq);
    end
    rtc_rdata = 32'h1F;
    @(posedge clk); #1;
    rtc_rdata = 32'h20;
    @(posedge clk); #1;
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_early: irq=%b required 0 in shadow-update cycle", irq);
    end
    @(posedge clk); #1;
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_rise: irq=%b required 1", irq);
    end
    cpu_access(1'b1, 2'd2, 32'h3, rd, cyc);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_clear: irq=%b required 0", irq);
    end
    repeat (6) begin
      @(posedge clk); #1;
      if (irq) irq_seen++;
    end
    tests_run++;
    if (irq_seen != 0) begin
      tests_failed++;
      $display("FAIL irq_persist: irq high %0d cycles required 0", irq_seen);
    end
    cpu_access(1'b0, 2'd2, '0, rd, cyc);
    tests_run++;
    if (rd !== 32'h1) begin
      tests_failed++;
      $display("FAIL ctrl_after_clear: ctrl=%h required 00000001", rd);
    end
    rtc_rdata = 32'h21;
    @(posedge clk); #1;
    rtc_rdata = 32'h22;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_w1c_collision();
    logic [W-1:0] rd;
    int cyc;
    rtc_rdata = 32'h20;
    @(posedge clk); #1;
    io_sel = 1'b1; io_we = 1'b1; io_addr = 2'd2; io_wdata = 32'h3;
    @(posedge clk); #1;
    io_sel = 1'b0;
    tests_run++;
    if (io_ready !== 1'b1 || irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL w1c_collide: ready=%b irq=%b required 1/1", io_ready, irq);
    end
    cpu_access(1'b0, 2'd2, '0, rd, cyc);
    tests_run++;
    if (rd !== 32'h3) begin
      tests_failed++;
      $display("FAIL w1c_pending: ctrl=%h required 00000003", rd);
    end
    cpu_access(1'b1, 2'd2, 32'h0, rd, cyc);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_mask: irq=%b required 0", irq);
    end
    cpu_access(1'b0, 2'd2, '0, rd, cyc);
    tests_run++;
    if (rd !== 32'h2) begin
      tests_failed++;
      $display("FAIL mask_keeps_pending: ctrl=%h required 00000002", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] rd1 = '0;
    logic [W-1:0] rd2 = '0;
    int at1 = 0;
    int at2 = 0;
    int pulses = 0;
    @(posedge clk); #1;
    io_sel = 1'b1; io_we = 1'b0; io_addr = 2'd1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (io_ready) begin
        pulses++;
        if (pulses == 1) begin
          at1 = k; rd1 = io_rdata; io_addr = 2'd2;
        end else begin
          at2 = k; rd2 = io_rdata; io_sel = 1'b0;
        end
      end
    end
    io_sel = 1'b0;
    tests_run++;
    if (pulses != 2 || at1 != 1 || at2 != 3) begin
      tests_failed++;
      $display("FAIL b2b_timing: pulses=%0d at=%0d,%0d required 2 at 1,3", pulses, at1, at2);
    end
    tests_run++;
    if (rd1 !== 32'h20 || rd2 !== 32'h2) begin
      tests_failed++;
      $display("FAIL b2b_data: rdata=%h,%h required 00000020,00000002", rd1, rd2);
    end
  endtask

  initial begin
    rst = 1'b1; io_sel = 1'b0; io_we = 1'b0; io_addr = 2'd0; io_wdata = '0;
    rtc_rdata = '0; rtc_ready = 1'b0;
    test_reset();
    test_alarm_rw();
    test_count_write();
    test_timeout();
    test_alarm_irq();
    test_w1c_collision();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
